// File: rtl/fm_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fm_readout_ctrl
// Purpose  : Read-side sweep of the per-kernel feature map RAMs into the
//            matrix-multiply accumulators, with aligned valid/clear/last.
// Revision : 1.0 - initial release
// ============================================================================
module fm_readout_ctrl #(
    parameter int FM_DEPTH    = 16,
    parameter int NUM_KERNELS = 2,
    parameter int ADDR_W      = 4,
    parameter int SEL_W       = 1,
    parameter int RD_LATENCY  = 2,
    parameter int MAC_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] fm_rd_addr,
    output logic [SEL_W-1:0]  ram_select,
    output logic              rd_issue,
    output logic              rd_valid,
    output logic              acc_clear,
    output logic              last_beat,
    output logic              product_rdy,
    output logic              fm_release,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] c_addr_last = ADDR_W'(FM_DEPTH - 1);
    localparam logic [SEL_W-1:0]  c_sel_last  = SEL_W'(NUM_KERNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;

    logic [RD_LATENCY-1:0] r_valid_pipe;
    logic [RD_LATENCY-1:0] r_clear_pipe;
    logic [RD_LATENCY-1:0] r_last_pipe;

    logic w_first_issue;
    logic w_last_issue;
    logic w_drain_done;

    // Beat markers are derived from the live request so they ride the same pipe as rd_issue
    assign w_first_issue = rd_issue && (fm_rd_addr == '0) && (ram_select == '0);
    assign w_last_issue  = rd_issue && (fm_rd_addr == c_addr_last) && (ram_select == c_sel_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            fm_rd_addr  <= '0;
            ram_select  <= '0;
            rd_issue    <= 1'b0;
            product_rdy <= 1'b0;
            fm_release  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            product_rdy <= 1'b0;
            fm_release  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_READ;
                        rd_issue   <= 1'b1;
                        fm_rd_addr <= '0;
                        ram_select <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_READ: begin
                    if (w_last_issue) begin
                        r_state    <= S_DRAIN;
                        rd_issue   <= 1'b0;
                        fm_rd_addr <= '0;
                        ram_select <= '0;
                    end else if (ram_select == c_sel_last) begin
                        ram_select <= '0;
                        fm_rd_addr <= fm_rd_addr + ADDR_W'(1);
                    end else begin
                        ram_select <= ram_select + SEL_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_drain_done) begin
                        r_state     <= S_DONE;
                        product_rdy <= 1'b1;
                        fm_release  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Wait for the full level to drop so a stale start cannot retrigger
                    if (!start) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    rd_issue   <= 1'b0;
                    fm_rd_addr <= '0;
                    ram_select <= '0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid_pipe <= '0;
            r_clear_pipe <= '0;
            r_last_pipe  <= '0;
        end else begin
            r_valid_pipe[0] <= rd_issue;
            r_clear_pipe[0] <= w_first_issue;
            r_last_pipe[0]  <= w_last_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_valid_pipe[i] <= r_valid_pipe[i-1];
                r_clear_pipe[i] <= r_clear_pipe[i-1];
                r_last_pipe[i]  <= r_last_pipe[i-1];
            end
        end
    end

    assign rd_valid  = r_valid_pipe[RD_LATENCY-1];
    assign acc_clear = r_clear_pipe[RD_LATENCY-1];
    assign last_beat = r_last_pipe[RD_LATENCY-1];

    // Drain ends one cycle before the final sum lands, since product_rdy is registered
    generate
        if (MAC_LATENCY == 1) begin : g_mac_direct
            assign w_drain_done = last_beat;
        end else begin : g_mac_pipe
            logic [MAC_LATENCY-2:0] r_mac_pipe;
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_mac_pipe <= '0;
                end else begin
                    r_mac_pipe[0] <= last_beat;
                    for (int i = 1; i < MAC_LATENCY - 1; i++) begin
                        r_mac_pipe[i] <= r_mac_pipe[i-1];
                    end
                end
            end
            assign w_drain_done = r_mac_pipe[MAC_LATENCY-2];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fm_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fm_readout_ctrl
// Purpose  : Self-checking bench for fm_readout_ctrl over four parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fm_readout_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start_v;
    int         which;
    int         vectors;
    int         miscompares;

    always #5 clk = ~clk;

    // Model parameters per instance: depth, kernels, read latency, mac latency
    int m_fd  [4] = '{4, 3, 1, 5};
    int m_nk  [4] = '{2, 3, 1, 3};
    int m_rd  [4] = '{2, 2, 1, 3};
    int m_mac [4] = '{1, 1, 1, 3};

    logic [1:0] d0_addr; logic d0_sel;
    logic d0_issue, d0_valid, d0_clear, d0_last, d0_prdy, d0_rel, d0_busy;
    logic [1:0] d1_addr; logic [1:0] d1_sel;
    logic d1_issue, d1_valid, d1_clear, d1_last, d1_prdy, d1_rel, d1_busy;
    logic       d2_addr; logic d2_sel;
    logic d2_issue, d2_valid, d2_clear, d2_last, d2_prdy, d2_rel, d2_busy;
    logic [2:0] d3_addr; logic [1:0] d3_sel;
    logic d3_issue, d3_valid, d3_clear, d3_last, d3_prdy, d3_rel, d3_busy;

    fm_readout_ctrl #(.FM_DEPTH(4), .NUM_KERNELS(2), .ADDR_W(2), .SEL_W(1),
                      .RD_LATENCY(2), .MAC_LATENCY(1)) u_dut0 (
        .clock(clk), .reset(rst), .start(start_v[0]),
        .fm_rd_addr(d0_addr), .ram_select(d0_sel), .rd_issue(d0_issue),
        .rd_valid(d0_valid), .acc_clear(d0_clear), .last_beat(d0_last),
        .product_rdy(d0_prdy), .fm_release(d0_rel), .busy(d0_busy));

    fm_readout_ctrl #(.FM_DEPTH(3), .NUM_KERNELS(3), .ADDR_W(2), .SEL_W(2),
                      .RD_LATENCY(2), .MAC_LATENCY(1)) u_dut1 (
        .clock(clk), .reset(rst), .start(start_v[1]),
        .fm_rd_addr(d1_addr), .ram_select(d1_sel), .rd_issue(d1_issue),
        .rd_valid(d1_valid), .acc_clear(d1_clear), .last_beat(d1_last),
        .product_rdy(d1_prdy), .fm_release(d1_rel), .busy(d1_busy));

    fm_readout_ctrl #(.FM_DEPTH(1), .NUM_KERNELS(1), .ADDR_W(1), .SEL_W(1),
                      .RD_LATENCY(1), .MAC_LATENCY(1)) u_dut2 (
        .clock(clk), .reset(rst), .start(start_v[2]),
        .fm_rd_addr(d2_addr), .ram_select(d2_sel), .rd_issue(d2_issue),
        .rd_valid(d2_valid), .acc_clear(d2_clear), .last_beat(d2_last),
        .product_rdy(d2_prdy), .fm_release(d2_rel), .busy(d2_busy));

    fm_readout_ctrl #(.FM_DEPTH(5), .NUM_KERNELS(3), .ADDR_W(3), .SEL_W(2),
                      .RD_LATENCY(3), .MAC_LATENCY(3)) u_dut3 (
        .clock(clk), .reset(rst), .start(start_v[3]),
        .fm_rd_addr(d3_addr), .ram_select(d3_sel), .rd_issue(d3_issue),
        .rd_valid(d3_valid), .acc_clear(d3_clear), .last_beat(d3_last),
        .product_rdy(d3_prdy), .fm_release(d3_rel), .busy(d3_busy));

    // Observed bundle: {issue, addr[3:0], sel[1:0], valid, clear, last, prdy, release, busy}
    logic [12:0] obs;
    always_comb begin
        obs = '0;
        case (which)
            0: obs = {d0_issue, 4'(d0_addr), 2'(d0_sel), d0_valid, d0_clear, d0_last, d0_prdy, d0_rel, d0_busy};
            1: obs = {d1_issue, 4'(d1_addr), 2'(d1_sel), d1_valid, d1_clear, d1_last, d1_prdy, d1_rel, d1_busy};
            2: obs = {d2_issue, 4'(d2_addr), 2'(d2_sel), d2_valid, d2_clear, d2_last, d2_prdy, d2_rel, d2_busy};
            3: obs = {d3_issue, 4'(d3_addr), 2'(d3_sel), d3_valid, d3_clear, d3_last, d3_prdy, d3_rel, d3_busy};
            default: obs = '0;
        endcase
    end

    function automatic int pass_len(input int w);
        return m_fd[w] * m_nk[w] + m_rd[w] + m_mac[w];
    endfunction

    // Cycle 0 = the cycle whose closing edge samples start high.
    // Start is high for cycles [0, drop_at), reset is driven for cycle rst_at (-1 = none).
    task automatic run_pass(input int w, input int drop_at, input int rst_at,
                            input int total, input string name);
        int n, rd, p, tend, b;
        logic [12:0] exp;
        which = w;
        n     = m_fd[w] * m_nk[w];
        rd    = m_rd[w];
        p     = pass_len(w);
        tend  = (drop_at > p) ? drop_at : p;
        for (int t = 0; t <= total; t++) begin
            @(negedge clk);
            exp = '0;
            if (!(rst_at >= 0 && t > rst_at)) begin
                if (t >= 1 && t <= n) begin
                    b          = t - 1;
                    exp[12]    = 1'b1;
                    exp[11:8]  = 4'(b / m_nk[w]);
                    exp[7:6]   = 2'(b % m_nk[w]);
                end
                exp[5] = (t >= 1 + rd) && (t <= n + rd);
                exp[4] = (t == 1 + rd);
                exp[3] = (t == n + rd);
                exp[2] = (t == p);
                exp[1] = (t == p);
                exp[0] = (t >= 1) && (t <= tend);
            end
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s dut%0d cycle %0d: got %b expected %b (issue,addr,sel,valid,clear,last,prdy,rel,busy)",
                         name, w, t, obs, exp);
            end
            start_v[w] = (t < drop_at) && !(rst_at >= 0 && t >= rst_at);
            rst        = (t == rst_at);
        end
        start_v[w] = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start_v = '0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 4; w++) begin
            which = w;
            #1;
            vectors++;
            if (obs !== 13'd0) begin
                miscompares++;
                $display("FAIL reset dut%0d: got %b expected %b", w, obs, 13'd0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_pass(0, 14, -1, 16, "basic");
    endtask

    task automatic test_stale_start();
        run_pass(0, 30, -1, 31, "stale_hold");
        run_pass(0, 1, -1, 13, "stale_rearm");
    endtask

    task automatic test_reset_mid_read();
        run_pass(0, 5, 5, 14, "reset_mid_read");
    endtask

    task automatic test_non_pow2();
        run_pass(1, 3, -1, 15, "non_pow2");
    endtask

    task automatic test_single_beat();
        run_pass(2, 1, -1, 6, "single_beat");
    endtask

    task automatic test_start_drop();
        run_pass(0, 4, -1, 13, "start_drop");
    endtask

    task automatic test_long_latency();
        run_pass(3, 2, -1, pass_len(3) + 3, "long_latency");
    endtask

    task automatic test_back_to_back();
        run_pass(0, pass_len(0), -1, pass_len(0) + 1, "b2b_first");
        run_pass(1, 1, -1, pass_len(1) + 1, "b2b_second");
        run_pass(0, pass_len(0), -1, pass_len(0) + 1, "b2b_third");
    endtask

    task automatic test_random();
        int w, p, drop, rst_at, total;
        for (int k = 0; k < 16; k++) begin
            w    = int'($urandom_range(0, 3));
            p    = pass_len(w);
            drop = int'($urandom_range(1, p + 4));
            if ($urandom_range(0, 3) == 0) begin
                rst_at = int'($urandom_range(1, p));
                drop   = rst_at;
                total  = rst_at + 3;
            end else begin
                rst_at = -1;
                total  = ((drop > p) ? drop : p) + 2;
            end
            run_pass(w, drop, rst_at, total, "random");
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        which       = 0;
        rst         = 1'b1;
        start_v     = '0;
        test_reset();
        test_basic();
        test_stale_start();
        test_reset_mid_read();
        test_non_pow2();
        test_single_beat();
        test_start_drop();
        test_long_latency();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
